// File: rtl/alarm_interval_timer.sv
// alarm_interval_timer: countdown timer that reads its interval length from
// the time-parameter store and produces the one-second tick for the alarm
// subsystem. A start request latches the interval select, reads back the
// programmed seconds one cycle later, counts them down and pulses expired.
module alarm_interval_timer #(
  parameter int CLK_PER_SEC = 4,
  parameter int PS_W        = 2
) (
  input  logic       clk,
  input  logic       g_reset,
  input  logic       start_timer,
  input  logic [1:0] interval_req,
  input  logic [3:0] value,
  output logic [1:0] interval,
  output logic       expired,
  output logic       busy,
  output logic [3:0] remaining,
  output logic       one_hz_en
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COUNT   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_PER_SEC - 1);

  state_t          state;
  state_t          state_nxt;
  logic [PS_W-1:0] prescaler;
  logic            tick;

  // Last prescaler cycle of a second while counting.
  assign tick = (state == COUNT) && (prescaler == PS_MAX);

  // State register; reset abandons any count without an expired pulse.
  always_ff @(posedge clk or posedge g_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (g_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; a start request always restarts through LOAD.
  always_comb begin
    // NOTE: default first, so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_timer) state_nxt = LOAD;
      LOAD: begin
        if (start_timer)         state_nxt = LOAD;
        else if (value == 4'd0)  state_nxt = EXPIRED;
        else                     state_nxt = COUNT;
      end
      COUNT: begin
        if (start_timer)                     state_nxt = LOAD;
        else if (tick && remaining == 4'd1)  state_nxt = EXPIRED;
      end
      EXPIRED: state_nxt = start_timer ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: interval latch, seconds counter and prescaler.
  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      interval  <= 2'd0;
      remaining <= 4'd0;
      prescaler <= '0;
    end else begin
      if (start_timer) interval <= interval_req;
      unique case (state)
        LOAD: begin
          // The store is sampled only here; reprogramming later cannot
          // disturb a running count.
          remaining <= value;
          prescaler <= '0;
        end
        COUNT: begin
          if (start_timer) begin
            prescaler <= '0;
          end else if (tick) begin
            prescaler <= '0;
            if (remaining != 4'd0) remaining <= remaining - 4'd1;
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        default: prescaler <= '0;
      endcase
    end
  end

  // Moore outputs decoded from state.
  assign expired   = (state == EXPIRED);
  assign busy      = (state == LOAD) || (state == COUNT);
  assign one_hz_en = tick;

endmodule

// File: tb/tb_alarm_interval_timer.sv
// Self-checking bench for alarm_interval_timer: directed scenarios plus a
// randomized run, all checked every cycle against an elapsed-time model.
module tb_alarm_interval_timer;

  localparam int CPS = 4;

  logic       clk = 1'b0;
  logic       g_reset;
  logic       start_timer;
  logic [1:0] interval_req;
  logic [3:0] value;
  logic [1:0] interval;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;
  logic       one_hz_en;

  alarm_interval_timer #(.CLK_PER_SEC(CPS), .PS_W(2)) dut (
    .clk          (clk),
    .g_reset      (g_reset),
    .start_timer  (start_timer),
    .interval_req (interval_req),
    .value        (value),
    .interval     (interval),
    .expired      (expired),
    .busy         (busy),
    .remaining    (remaining),
    .one_hz_en    (one_hz_en)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: phase of the request plus elapsed cycles since load.
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_DONE} mphase_t;
  mphase_t m_phase;
  int m_int, m_n, m_rem, m_elapsed;

  int n_exp, n_tick, cyc, exp_at;

  task automatic model_reset();
    m_phase = M_IDLE; m_int = 0; m_n = 0; m_rem = 0; m_elapsed = 0;
  endtask

  task automatic model_edge();
    if (g_reset) begin
      model_reset();
      return;
    end
    case (m_phase)
      M_IDLE: if (start_timer) begin m_int = interval_req; m_phase = M_LOAD; end
      M_LOAD: begin
        m_n = value; m_rem = value; m_elapsed = 0;
        if (start_timer) m_int = interval_req;
        else m_phase = (value == 0) ? M_DONE : M_RUN;
      end
      M_RUN: begin
        if (start_timer) begin
          m_int = interval_req; m_phase = M_LOAD;
        end else begin
          m_elapsed++;
          if (m_elapsed % CPS == 0) begin
            m_rem = m_n - m_elapsed / CPS;
            if (m_rem == 0) m_phase = M_DONE;
          end
        end
      end
      default: begin
        if (start_timer) begin m_int = interval_req; m_phase = M_LOAD; end
        else m_phase = M_IDLE;
      end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".interval"},  interval,  m_int);
    check({tag, ".busy"},      busy,      (m_phase == M_LOAD || m_phase == M_RUN));
    check({tag, ".expired"},   expired,   (m_phase == M_DONE));
    check({tag, ".remaining"}, remaining, m_rem);
    check({tag, ".one_hz_en"}, one_hz_en, (m_phase == M_RUN && (m_elapsed % CPS) == CPS - 1));
  endtask

  // One clock: drive inputs, let the edge happen, compare on the falling edge.
  task automatic step(input string tag, input logic s, input logic [1:0] req, input logic [3:0] v);
    start_timer = s; interval_req = req; value = v;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    if (expired) begin
      n_exp++;
      if (exp_at == 0) exp_at = cyc;
    end
    if (one_hz_en) n_tick++;
    check_outputs(tag);
  endtask

  task automatic begin_scn();
    n_exp = 0; n_tick = 0; cyc = 0; exp_at = 0;
  endtask

  initial begin
    logic [3:0] rv;
    g_reset = 1'b1; start_timer = 1'b0; interval_req = 2'd0; value = 4'd0;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk); @(negedge clk);
    g_reset = 1'b0;

    // Basic: interval 2, 9 seconds -> expiry observed after edge k+37.
    begin_scn();
    step("basic", 1'b1, 2'd2, 4'd9);
    check("basic.interval_latch", interval, 2);
    step("basic", 1'b0, 2'd0, 4'd9);
    check("basic.loaded", remaining, 9);
    for (int i = 0; i < 44; i++) step("basic", 1'b0, 2'd0, 4'd9);
    check("basic.latency", exp_at, 38);
    check("basic.exp_count", n_exp, 1);
    check("basic.ticks", n_tick, 9);
    check("basic.busy_after", busy, 0);

    // Zero value: expires right after load, never ticks.
    begin_scn();
    step("zero", 1'b1, 2'd0, 4'd0);
    for (int i = 0; i < 6; i++) step("zero", 1'b0, 2'd0, 4'd0);
    check("zero.latency", exp_at, 2);
    check("zero.exp_count", n_exp, 1);
    check("zero.ticks", n_tick, 0);

    // Value latch: store reprogrammed to 12 during COUNT is ignored.
    begin_scn();
    step("latch", 1'b1, 2'd1, 4'd3);
    step("latch", 1'b0, 2'd1, 4'd3);
    for (int i = 0; i < 18; i++) step("latch", 1'b0, 2'd1, 4'd12);
    check("latch.latency", exp_at, 14);
    check("latch.exp_count", n_exp, 1);
    check("latch.ticks", n_tick, 3);

    // Restart after two ticks with interval 3 / value 2.
    begin_scn();
    step("restart", 1'b1, 2'd0, 4'd6);
    for (int i = 0; i < 9; i++) step("restart", 1'b0, 2'd0, 4'd6);
    check("restart.pre_ticks", n_tick, 2);
    step("restart", 1'b1, 2'd3, 4'd2);
    check("restart.interval", interval, 3);
    step("restart", 1'b0, 2'd0, 4'd2);
    check("restart.reload", remaining, 2);
    for (int i = 0; i < 14; i++) step("restart", 1'b0, 2'd0, 4'd2);
    check("restart.latency", exp_at, 20);
    check("restart.exp_count", n_exp, 1);
    check("restart.ticks", n_tick, 4);

    // Max interval: 15 ticks, no wrap.
    begin_scn();
    step("max", 1'b1, 2'd3, 4'd15);
    for (int i = 0; i < 66; i++) step("max", 1'b0, 2'd3, 4'd15);
    check("max.latency", exp_at, 62);
    check("max.exp_count", n_exp, 1);
    check("max.ticks", n_tick, 15);
    check("max.remaining_end", remaining, 0);

    // Asynchronous reset mid-count at remaining=5.
    begin_scn();
    step("rst_mid", 1'b1, 2'd1, 4'd9);
    for (int i = 0; i < 60 && m_rem != 5; i++) step("rst_mid", 1'b0, 2'd1, 4'd9);
    check("rst_mid.reached5", remaining, 5);
    #2 g_reset = 1'b1;
    #1;
    model_reset();
    check("rst_mid.interval", interval, 0);
    check("rst_mid.busy", busy, 0);
    check("rst_mid.remaining", remaining, 0);
    check("rst_mid.expired", expired, 0);
    check("rst_mid.one_hz_en", one_hz_en, 0);
    step("rst_mid", 1'b0, 2'd1, 4'd9);
    g_reset = 1'b0;
    n_exp = 0;
    for (int i = 0; i < 50; i++) step("rst_mid", 1'b0, 2'd1, 4'd9);
    check("rst_mid.no_expiry", n_exp, 0);

    // Randomized traffic with occasional restarts, reprogramming and resets.
    rv = 4'd5;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) rv = 4'($urandom_range(0, 15));
      step("rand", ($urandom_range(0, 29) == 0), 2'($urandom_range(0, 3)), rv);
      if ($urandom_range(0, 499) == 0) begin
        #2 g_reset = 1'b1;
        #1;
        model_reset();
        check_outputs("rand_rst");
        #1 g_reset = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
